// File: rtl/clock_pkg.sv
// Shared encodings, field limits and calendar helper for the clock edit path.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_DEFAULT = 2'd0,
    MODE_TIME    = 2'd1,
    MODE_DATE    = 2'd2,
    MODE_ALARM   = 2'd3
  } clock_mode_e;

  localparam logic [1:0] FIELD_HI  = 2'd0;
  localparam logic [1:0] FIELD_MID = 2'd1;
  localparam logic [1:0] FIELD_LO  = 2'd2;

  localparam logic [7:0] HH_MIN = 8'h00;
  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MM_MIN = 8'h00;
  localparam logic [7:0] MM_MAX = 8'h59;
  localparam logic [7:0] SS_MIN = 8'h00;
  localparam logic [7:0] SS_MAX = 8'h59;
  localparam logic [7:0] DD_MIN = 8'h01;
  localparam logic [7:0] DD_MAX = 8'h31;
  localparam logic [7:0] MO_MIN = 8'h01;
  localparam logic [7:0] MO_MAX = 8'h12;
  localparam logic [7:0] YY_MIN = 8'h00;
  localparam logic [7:0] YY_MAX = 8'h99;

  // BCD month/year in, BCD day count out; every year divisible by 4 is a leap year.
  function automatic logic [7:0] days_in_month(input logic [7:0] mo, input logic [7:0] yy);
    logic [6:0] y;
    logic [7:0] d;
    y = 7'(yy[7:4]) * 7'd10 + 7'(yy[3:0]);
    case (mo)
      8'h02:                      d = (y[1:0] == 2'b00) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
      default:                    d = 8'h31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// One BCD field increment (units or tens digit) with min/max wrap rules.
module bcd_field_step (
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       inc_units,
  input  logic       inc_tens,
  output logic [7:0] next
);

  logic [3:0] tens;
  logic [3:0] units;

  // Two-digit BCD compares correctly as plain unsigned bytes.
  always_comb begin
    tens  = value[7:4];
    units = value[3:0];
    if (inc_units) begin
      units = (units == 4'd9) ? 4'd0 : units + 4'd1;
      if ({tens, units} > max) units = 4'd0;
      if ({tens, units} < min) units = 4'd1;
    end else if (inc_tens) begin
      tens = ({tens + 4'd1, units} <= max) ? tens + 4'd1 : 4'd0;
      if ({tens, units} < min) units = 4'd1;
    end
    next = {tens, units};
  end

endmodule

// File: rtl/clock_edit_sequencer.sv
// Set-time/date/alarm sequencer: loads a BCD shadow, edits one field at a time,
// commits on mode exit and owns the alarm registers.
module clock_edit_sequencer
  import clock_pkg::*;
#(
  parameter int unsigned M_FREQ    = 1,
  parameter int unsigned BLINK_DIV = (M_FREQ / 2 > 0) ? M_FREQ / 2 : 1
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [1:0]  clk_mode,
  input  logic [1:0]  vButton,
  input  logic        vNext,
  input  logic [23:0] cur_time,
  input  logic [23:0] cur_date,
  output logic [23:0] edit_value,
  output logic [1:0]  field_sel,
  output logic        blink,
  output logic        time_load,
  output logic        date_load,
  output logic [15:0] alarm_hhmm,
  output logic        alarm_en
);

  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StEdit, StCommit} state_e;

  state_e          state_q, state_d;
  clock_mode_e     mode_q, mode_d;
  logic [23:0]     edit_q, edit_d;
  logic [1:0]      field_q, field_d;
  logic            blink_q, blink_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            time_load_q, time_load_d;
  logic            date_load_q, date_load_d;
  logic [15:0]     alarm_q, alarm_d;
  logic            alarm_en_q, alarm_en_d;

  logic [7:0] fval, fmin, fmax, fnext, day_lim;

  always_comb begin
    case (field_q)
      FIELD_MID: fval = edit_q[15:8];
      FIELD_LO:  fval = edit_q[7:0];
      default:   fval = edit_q[23:16];
    endcase
  end

  always_comb begin
    fmin = HH_MIN;
    fmax = HH_MAX;
    if (mode_q == MODE_DATE) begin
      case (field_q)
        FIELD_HI:  begin fmin = DD_MIN; fmax = DD_MAX; end
        FIELD_MID: begin fmin = MO_MIN; fmax = MO_MAX; end
        default:   begin fmin = YY_MIN; fmax = YY_MAX; end
      endcase
    end else begin
      case (field_q)
        FIELD_HI:  begin fmin = HH_MIN; fmax = HH_MAX; end
        FIELD_MID: begin fmin = MM_MIN; fmax = MM_MAX; end
        default:   begin fmin = SS_MIN; fmax = SS_MAX; end
      endcase
    end
  end

  // Both buttons at once count as a units press only.
  bcd_field_step u_step (
    .value     (fval),
    .min       (fmin),
    .max       (fmax),
    .inc_units (vButton[0]),
    .inc_tens  (vButton[1] & ~vButton[0]),
    .next      (fnext)
  );

  assign day_lim = days_in_month(edit_q[15:8], edit_q[7:0]);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    edit_d      = edit_q;
    field_d     = field_q;
    blink_d     = 1'b0;
    cnt_d       = '0;
    time_load_d = 1'b0;
    date_load_d = 1'b0;
    alarm_d     = alarm_q;
    alarm_en_d  = alarm_en_q;
    unique case (state_q)
      StIdle: begin
        if (clk_mode != MODE_DEFAULT) begin
          state_d = StLoad;
          mode_d  = clock_mode_e'(clk_mode);
        end
      end
      StLoad: begin
        case (mode_q)
          MODE_TIME: edit_d = cur_time;
          MODE_DATE: edit_d = cur_date;
          default:   edit_d = {alarm_q, 7'b0, alarm_en_q};
        endcase
        field_d = FIELD_HI;
        state_d = StEdit;
      end
      StEdit: begin
        if (clk_mode != mode_q) begin
          // Commit side effects land on this edge so they are valid during COMMIT.
          state_d = StCommit;
          case (mode_q)
            MODE_TIME: time_load_d = 1'b1;
            MODE_DATE: begin
              date_load_d = 1'b1;
              if (edit_q[23:16] > day_lim) edit_d[23:16] = day_lim;
            end
            default: begin
              alarm_d    = edit_q[23:8];
              alarm_en_d = edit_q[0];
            end
          endcase
        end else begin
          if (vNext) begin
            blink_d = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
            blink_d = ~blink_q;
            cnt_d   = '0;
          end else begin
            blink_d = blink_q;
            cnt_d   = cnt_q + CntW'(1);
          end
          if (vButton != 2'b00) begin
            if (mode_q == MODE_ALARM && field_q == FIELD_LO) begin
              edit_d[0] = ~edit_q[0];
            end else begin
              case (field_q)
                FIELD_MID: edit_d[15:8]  = fnext;
                FIELD_LO:  edit_d[7:0]   = fnext;
                default:   edit_d[23:16] = fnext;
              endcase
            end
          end
          if (vNext) field_d = (field_q == FIELD_LO) ? FIELD_HI : field_q + 2'd1;
        end
      end
      StCommit: begin
        mode_d  = clock_mode_e'(clk_mode);
        state_d = (clk_mode == MODE_DEFAULT) ? StIdle : StLoad;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= MODE_DEFAULT;
      edit_q      <= '0;
      field_q     <= FIELD_HI;
      blink_q     <= 1'b0;
      cnt_q       <= '0;
      time_load_q <= 1'b0;
      date_load_q <= 1'b0;
      alarm_q     <= '0;
      alarm_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      edit_q      <= edit_d;
      field_q     <= field_d;
      blink_q     <= blink_d;
      cnt_q       <= cnt_d;
      time_load_q <= time_load_d;
      date_load_q <= date_load_d;
      alarm_q     <= alarm_d;
      alarm_en_q  <= alarm_en_d;
    end
  end

  assign edit_value = edit_q;
  assign field_sel  = field_q;
  assign blink      = blink_q;
  assign time_load  = time_load_q;
  assign date_load  = date_load_q;
  assign alarm_hhmm = alarm_q;
  assign alarm_en   = alarm_en_q;

endmodule

// File: tb/tb_clock_edit_sequencer.sv
// Self-checking bench for clock_edit_sequencer: directed scenarios plus a randomized
// edit session checked against a decimal reference model.
module tb_clock_edit_sequencer;

  logic        mclk;
  logic        rst;
  logic [1:0]  clk_mode;
  logic [1:0]  vButton;
  logic        vNext;
  logic [23:0] cur_time;
  logic [23:0] cur_date;
  logic [23:0] edit_value;
  logic [1:0]  field_sel;
  logic        blink;
  logic        time_load;
  logic        date_load;
  logic [15:0] alarm_hhmm;
  logic        alarm_en;

  int vectors = 0;
  int miscompares = 0;

  clock_edit_sequencer #(.M_FREQ(10)) dut (
    .mclk       (mclk),
    .rst        (rst),
    .clk_mode   (clk_mode),
    .vButton    (vButton),
    .vNext      (vNext),
    .cur_time   (cur_time),
    .cur_date   (cur_date),
    .edit_value (edit_value),
    .field_sel  (field_sel),
    .blink      (blink),
    .time_load  (time_load),
    .date_load  (date_load),
    .alarm_hhmm (alarm_hhmm),
    .alarm_en   (alarm_en)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int lim_lo(int m, int f);
    return (m == 2 && f != 2) ? 1 : 0;
  endfunction

  function automatic int lim_hi(int m, int f);
    if (m == 2) return (f == 0) ? 31 : (f == 1) ? 12 : 99;
    return (f == 0) ? 23 : 59;
  endfunction

  function automatic int inc_u(int v, int lo, int hi);
    int t = v / 10;
    int u = v % 10;
    u = (u == 9) ? 0 : u + 1;
    if (t * 10 + u > hi) u = 0;
    if (t * 10 + u < lo) u = 1;
    return t * 10 + u;
  endfunction

  function automatic int inc_t(int v, int lo, int hi);
    int t = v / 10;
    int u = v % 10;
    t = ((t + 1) * 10 + u <= hi) ? t + 1 : 0;
    if (t * 10 + u < lo) u = 1;
    return t * 10 + u;
  endfunction

  function automatic logic [7:0] bcd(int d);
    logic [7:0] r;
    r[7:4] = 4'(d / 10);
    r[3:0] = 4'(d % 10);
    return r;
  endfunction

  function automatic int dim(int mo, int yy);
    if (mo == 2) return (yy % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step();
    @(negedge mclk);
  endtask

  task automatic enter(input logic [1:0] m);
    clk_mode = m;
    step();
    step();
  endtask

  task automatic press(input logic [1:0] b, input logic n);
    vButton = b;
    vNext   = n;
    step();
    vButton = 2'b00;
    vNext   = 1'b0;
  endtask

  task automatic leave(input logic [1:0] m, output int tl, output int dl,
                       output logic [23:0] sv);
    tl = 0;
    dl = 0;
    sv = '0;
    clk_mode = m;
    for (int i = 0; i < 4; i++) begin
      step();
      if (time_load || date_load) sv = edit_value;
      if (time_load) tl++;
      if (date_load) dl++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int strobes = 0;
    rst = 1'b0;
    clk_mode = 2'd0; vButton = 2'b00; vNext = 1'b0;
    cur_time = 24'h123456; cur_date = 24'h010123;
    step(); step();
    vectors++;
    if ({edit_value, field_sel, blink, time_load, date_load, alarm_hhmm, alarm_en} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h/%0d/%b/%b/%b/%h/%b, required all zero", edit_value,
               field_sel, blink, time_load, date_load, alarm_hhmm, alarm_en);
    end
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (time_load || date_load || blink || edit_value != 0) strobes++;
    end
    vectors++;
    if (strobes !== 0) begin
      miscompares++;
      $display("FAIL idle_quiet: %0d active cycles, required 0", strobes);
    end
  endtask

  task automatic test_set_time();
    int tl, dl;
    logic [23:0] sv;
    cur_time = 24'h123456;
    enter(2'd1);
    vectors++;
    if (edit_value !== 24'h123456) begin
      miscompares++;
      $display("FAIL time_load_shadow: got %h, required 123456", edit_value);
    end
    for (int i = 0; i < 3; i++) press(2'b01, 1'b0);
    press(2'b00, 1'b1);
    press(2'b10, 1'b0);
    vectors++;
    if (edit_value !== 24'h154456 || field_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL time_edit: got %h f%0d, required 154456 f1", edit_value, field_sel);
    end
    leave(2'd0, tl, dl, sv);
    vectors++;
    if (tl !== 1 || dl !== 0 || sv !== 24'h154456) begin
      miscompares++;
      $display("FAIL time_commit: tl=%0d dl=%0d val=%h, required 1 0 154456", tl, dl, sv);
    end
  endtask

  task automatic test_wraps();
    logic [23:0] start [4];
    int          nexts [4];
    logic [1:0]  btn   [4];
    logic [23:0] expv  [4];
    int tl, dl;
    logic [23:0] sv;
    start = '{24'h230000, 24'h190000, 24'h005900, 24'h005900};
    nexts = '{0, 0, 1, 1};
    btn   = '{2'b01, 2'b10, 2'b01, 2'b10};
    expv  = '{24'h200000, 24'h090000, 24'h005000, 24'h000900};
    for (int k = 0; k < 4; k++) begin
      cur_time = start[k];
      enter(2'd1);
      for (int j = 0; j < nexts[k]; j++) press(2'b00, 1'b1);
      press(btn[k], 1'b0);
      vectors++;
      if (edit_value !== expv[k]) begin
        miscompares++;
        $display("FAIL wrap_%0d: got %h, required %h", k, edit_value, expv[k]);
      end
      leave(2'd0, tl, dl, sv);
      vectors++;
      if (tl !== 1 || sv !== expv[k]) begin
        miscompares++;
        $display("FAIL wrap_commit_%0d: tl=%0d val=%h, required 1 %h", k, tl, sv, expv[k]);
      end
    end
  endtask

  task automatic test_date_clamp();
    logic [23:0] start [2];
    logic [23:0] edited [2];
    logic [23:0] clamped [2];
    int tl, dl;
    logic [23:0] sv;
    start   = '{24'h310123, 24'h310124};
    edited  = '{24'h310223, 24'h310224};
    clamped = '{24'h280223, 24'h290224};
    for (int k = 0; k < 2; k++) begin
      cur_date = start[k];
      enter(2'd2);
      press(2'b00, 1'b1);
      press(2'b01, 1'b0);
      vectors++;
      if (edit_value !== edited[k]) begin
        miscompares++;
        $display("FAIL date_edit_%0d: got %h, required %h", k, edit_value, edited[k]);
      end
      leave(2'd0, tl, dl, sv);
      vectors++;
      if (dl !== 1 || tl !== 0 || sv !== clamped[k] || edit_value !== clamped[k]) begin
        miscompares++;
        $display("FAIL date_clamp_%0d: dl=%0d tl=%0d val=%h shadow=%h, required 1 0 %h", k,
                 dl, tl, sv, edit_value, clamped[k]);
      end
    end
  endtask

  task automatic test_time_to_alarm();
    int tl, dl;
    logic [23:0] sv;
    cur_time = 24'h010203;
    enter(2'd1);
    leave(2'd3, tl, dl, sv);
    vectors++;
    if (tl !== 1 || dl !== 0 || sv !== 24'h010203) begin
      miscompares++;
      $display("FAIL mode_1_to_3: tl=%0d dl=%0d val=%h, required 1 0 010203", tl, dl, sv);
    end
    vectors++;
    if (edit_value !== 24'h000000 || field_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL alarm_load: got %h f%0d, required 000000 f0", edit_value, field_sel);
    end
    for (int i = 0; i < 7; i++) press(2'b01, 1'b0);
    press(2'b00, 1'b1);
    for (int i = 0; i < 3; i++) press(2'b10, 1'b0);
    press(2'b00, 1'b1);
    press(2'b11, 1'b0);
    vectors++;
    if (edit_value !== 24'h073001) begin
      miscompares++;
      $display("FAIL alarm_edit: got %h, required 073001", edit_value);
    end
    leave(2'd0, tl, dl, sv);
    vectors++;
    if (tl !== 0 || dl !== 0 || alarm_hhmm !== 16'h0730 || alarm_en !== 1'b1) begin
      miscompares++;
      $display("FAIL alarm_commit: tl=%0d dl=%0d alarm=%h en=%b, required 0 0 0730 1", tl, dl,
               alarm_hhmm, alarm_en);
    end
  endtask

  task automatic test_reset_mid_edit();
    int strobes = 0;
    int tl, dl;
    logic [23:0] sv;
    enter(2'd3);
    press(2'b01, 1'b0);
    press(2'b00, 1'b1);
    #2 rst = 1'b0;
    clk_mode = 2'd0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst = 1'b1;
      step();
      if (time_load || date_load) strobes++;
    end
    vectors++;
    if (strobes !== 0 || alarm_hhmm !== 16'h0 || alarm_en !== 1'b0 || field_sel !== 2'd0 ||
        edit_value !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_mid_edit: strobes=%0d alarm=%h en=%b f%0d val=%h, required 0 0 0 0 0",
               strobes, alarm_hhmm, alarm_en, field_sel, edit_value);
    end
    cur_time = 24'h214700;
    enter(2'd1);
    vectors++;
    if (edit_value !== 24'h214700) begin
      miscompares++;
      $display("FAIL after_reset_load: got %h, required 214700", edit_value);
    end
    leave(2'd0, tl, dl, sv);
  endtask

  task automatic test_blink();
    int tl, dl;
    logic [23:0] sv;
    cur_time = 24'h000000;
    enter(2'd1);
    for (int n = 0; n < 12; n++) begin
      vectors++;
      if (blink !== 1'(((n / 5) % 2))) begin
        miscompares++;
        $display("FAIL blink_phase_%0d: got %b, required %b", n, blink, 1'(((n / 5) % 2)));
      end
      step();
    end
    press(2'b00, 1'b1);
    vectors++;
    if (blink !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_field_change: got %b, required 0", blink);
    end
    leave(2'd0, tl, dl, sv);
    vectors++;
    if (blink !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_idle: got %b, required 0", blink);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int m;
      int fs;
      int op;
      int fv [3];
      int tl, dl;
      logic [23:0] sv;
      logic [23:0] want;
      m  = $urandom_range(2, 1);
      fs = 0;
      for (int f = 0; f < 3; f++) fv[f] = $urandom_range(lim_hi(m, f), lim_lo(m, f));
      if (m == 1) cur_time = {bcd(fv[0]), bcd(fv[1]), bcd(fv[2])};
      else        cur_date = {bcd(fv[0]), bcd(fv[1]), bcd(fv[2])};
      enter(2'(m));
      vectors++;
      if (edit_value !== {bcd(fv[0]), bcd(fv[1]), bcd(fv[2])}) begin
        miscompares++;
        $display("FAIL rnd_load_%0d: got %h, required %h", it, edit_value,
                 {bcd(fv[0]), bcd(fv[1]), bcd(fv[2])});
      end
      for (int s = 0; s < 12; s++) begin
        op = $urandom_range(4, 0);
        case (op)
          0: begin press(2'b01, 1'b0); fv[fs] = inc_u(fv[fs], lim_lo(m, fs), lim_hi(m, fs)); end
          1: begin press(2'b10, 1'b0); fv[fs] = inc_t(fv[fs], lim_lo(m, fs), lim_hi(m, fs)); end
          2: begin press(2'b11, 1'b0); fv[fs] = inc_u(fv[fs], lim_lo(m, fs), lim_hi(m, fs)); end
          3: begin press(2'b00, 1'b1); fs = (fs + 1) % 3; end
          default: begin
            press(2'b01, 1'b1);
            fv[fs] = inc_u(fv[fs], lim_lo(m, fs), lim_hi(m, fs));
            fs = (fs + 1) % 3;
          end
        endcase
        vectors++;
        if (edit_value !== {bcd(fv[0]), bcd(fv[1]), bcd(fv[2])} || field_sel !== 2'(fs)) begin
          miscompares++;
          $display("FAIL rnd_edit_%0d_%0d: got %h f%0d, required %h f%0d", it, s, edit_value,
                   field_sel, {bcd(fv[0]), bcd(fv[1]), bcd(fv[2])}, fs);
        end
      end
      if (m == 2 && fv[0] > dim(fv[1], fv[2])) fv[0] = dim(fv[1], fv[2]);
      want = {bcd(fv[0]), bcd(fv[1]), bcd(fv[2])};
      leave(2'd0, tl, dl, sv);
      vectors++;
      if (tl !== ((m == 1) ? 1 : 0) || dl !== ((m == 2) ? 1 : 0) || sv !== want) begin
        miscompares++;
        $display("FAIL rnd_commit_%0d: mode %0d tl=%0d dl=%0d val=%h, required val %h", it, m,
                 tl, dl, sv, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_wraps();
    test_date_clamp();
    test_time_to_alarm();
    test_reset_mid_edit();
    test_blink();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_edit_sequencer.md
Name: clock_edit_sequencer

Overview:
Sequences the set-time, set-date and set-alarm modes of the digital clock. It consumes the mode code and one-cycle virtual button pulses from the button controller, and edits a BCD shadow copy of the selected target one field at a time. On mode exit it commits the shadow to the timekeeping registers with a one-cycle load strobe. It owns the alarm registers and drives a field-blink signal for the display mux.

Parameters:
M_FREQ, 1, main clock frequency in Hz; 1/10/100 for simulation, 20000000 on the board.
BLINK_DIV, M_FREQ/2, mclk cycles per blink phase; minimum 1.

Ports:
mclk  in  1  main clock
rst  in  1  asynchronous reset, active-low
clk_mode  in  2  0=default, 1=set time, 2=set date, 3=set alarm
vButton  in  2  1-cycle pulses; [0]=increment units digit, [1]=increment tens digit
vNext  in  1  1-cycle pulse; advance to the next field
cur_time  in  24  BCD {hh,mm,ss} from the timekeeper
cur_date  in  24  BCD {dd,mo,yy} from the calendar
edit_value  out  24  shadow being edited; BCD, 3 fields of 8 bits (2 digits)
field_sel  out  2  field being edited: 0=hi {hh/dd}, 1=mid {mm/mo}, 2=lo {ss/yy/alarm-enable}
blink  out  1  blink phase for the selected field
time_load  out  1  1-cycle strobe: load edit_value into the timekeeper
date_load  out  1  1-cycle strobe: load edit_value into the calendar
alarm_hhmm  out  16  committed alarm, BCD {hh,mm}
alarm_en  out  1  committed alarm enable

Behaviour:
- Reset (rst=0, async): state IDLE, mode_q=0, all outputs 0. A reset mid-edit discards the shadow and emits no load strobe.
- FSM states: IDLE, LOAD, EDIT, COMMIT. mode_q is a registered copy of clk_mode, captured on entering LOAD.
- IDLE: clk_mode!=0 -> LOAD.
- LOAD (1 cycle): capture the shadow. Mode 1 -> cur_time. Mode 2 -> cur_date. Mode 3 -> {alarm_hhmm, 7'b0, alarm_en}. Set field_sel=0, then go to EDIT.
- EDIT: clk_mode!=mode_q -> COMMIT. Buttons arriving in that same cycle are ignored.
- COMMIT (1 cycle): exactly one action.
  - Mode 1: time_load=1.
  - Mode 2: date_load=1, with the day clamped (below).
  - Mode 3: alarm regs take the shadow; alarm_en takes shadow bit 0.
  - edit_value is valid while the strobe is high.
  - Next state: clk_mode==0 -> IDLE, else LOAD. So a 1->2 transition commits the time, then loads the date.
- Field counts: modes 1 and 2 use 3 fields; mode 3 uses 3 fields, where field 2 is the enable bit. vNext cycles 0->1->2->0.
- Field limits (min..max):
  - hh 00..23; mm and ss 00..59.
  - dd 01..31; mo 01..12; yy 00..99.
  - Mode 3 field 2: either vButton bit toggles the enable.
- Units increment: units = (units==9) ? 0 : units+1. If the result is > max, units=0. If the result is < min, units=1.
- Tens increment: if (tens+1)*10+units <= max, then tens+1; else tens=0. If the result is < min, units=1.
- vButton=2'b11 in the same cycle: units increment only.
- vNext together with vButton: the increment applies to the current field, and field_sel advances in the same edge.
- Date clamp at commit: the day is limited to days-in-month.
  - 30-day months: 04, 06, 09, 11.
  - Feb: 29 if yy%4==0, else 28.
  - The clamped value is also written back to the shadow.
- Blink:
  - Counter of ceil(log2(BLINK_DIV)) bits; blink toggles on every BLINK_DIV-th cycle in EDIT.
  - The counter clears and blink=0 on LOAD and on any field change.
  - blink=0 outside EDIT.
- Outputs are registered; edit_value reflects a button pulse on the cycle after the pulse.

Decomposition:
- Package clock_pkg holds:
  - mode encodings: MODE_DEFAULT, MODE_TIME, MODE_DATE, MODE_ALARM;
  - field indices;
  - per-field BCD min/max constants;
  - the days-in-month function.
- Sub-module bcd_field_step: combinational. Inputs: 8-bit BCD value, min, max, inc_units, inc_tens. Output: next 8-bit BCD value. It is instantiated once, muxed by field_sel.

Test Plan:
1. Reset, then release with clk_mode=0 -> all outputs 0; no strobes for 100 cycles.
2. cur_time=12:34:56, clk_mode 0->1, vButton[0] x3 on hh, vNext, vButton[1] on mm, clk_mode->0 -> edit_value=15:44:56; single time_load pulse; then IDLE.
3. Wrap checks on hh: 23 +units -> 20; 19 +tens -> 09. On mm: 59 +units -> 50; 59 +tens -> 09.
4. Date clamp: cur_date=31/01/23; mode 2; vNext, mo +units -> 31/02/23; exit -> date_load with 28/02/23. The same steps from 31/01/24 -> 29/02/24.
5. Direct mode change 1->3 -> time_load pulse, LOAD, then alarm edit. Set 07:30, toggle the enable, exit -> alarm_hhmm=16'h0730, alarm_en=1, no date_load.
6. rst low in the middle of an edit -> no strobe; on release, alarm_hhmm=0, alarm_en=0, field_sel=0, state IDLE.
